// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the I-memory request at cur_pc, buffers the
// returned word while ID is stalled, and loads the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] cur_pc,
    input  logic [15:0] pre_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        mem_req,
    input  logic        mem_ready,
    input  logic [15:0] mem_data,
    output logic [15:0] id_inst,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic        fetch_err
);

    localparam int unsigned WAIT_W      = 4;
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state;
    logic [15:0]         holdInst;
    logic [15:0]         holdPc;
    logic [15:0]         holdNext;
    logic [WAIT_W-1:0]   waitCnt;
    logic [WAIT_W-1:0]   waitNext;

    // Saturating memory-wait count for the current fetch.
    assign waitNext = (waitCnt >= TIMEOUT_CNT) ? TIMEOUT_CNT : waitCnt + WAIT_W'(1);

    // Request follows state directly; held low while reset is asserted.
    assign mem_req = (state == FETCH) && rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            cur_pc    <= RESET_PC;
            id_inst   <= NOP_INST;
            id_pc     <= 16'h0000;
            id_valid  <= 1'b0;
            fetch_err <= 1'b0;
            waitCnt   <= '0;
            holdInst  <= 16'h0000;
            holdPc    <= 16'h0000;
            holdNext  <= 16'h0000;
        end else if (redirect) begin
            // Correction wins over everything; any word returning now is dropped.
            state    <= FETCH;
            cur_pc   <= redirect_pc;
            id_inst  <= NOP_INST;
            id_pc    <= 16'h0000;
            id_valid <= 1'b0;
            waitCnt  <= '0;
            holdInst <= 16'h0000;
            holdPc   <= 16'h0000;
            holdNext <= 16'h0000;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        waitCnt <= '0;
                        if (!stall) begin
                            id_inst  <= mem_data;
                            id_pc    <= cur_pc;
                            id_valid <= 1'b1;
                            cur_pc   <= pre_pc;
                        end else begin
                            holdInst <= mem_data;
                            holdPc   <= cur_pc;
                            holdNext <= pre_pc;
                            state    <= HOLD;
                        end
                    end else begin
                        waitCnt <= waitNext;
                        if (waitNext == TIMEOUT_CNT) begin
                            fetch_err <= 1'b1;
                        end
                        if (!stall) begin
                            id_inst  <= NOP_INST;
                            id_valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    // Release the buffered word once ID can take it.
                    if (!stall) begin
                        id_inst  <= holdInst;
                        id_pc    <= holdPc;
                        id_valid <= 1'b1;
                        cur_pc   <= holdNext;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table driven through a
// scoreboard queue, followed by timeout and asynchronous-reset sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] cur_pc;
    logic [15:0] pre_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        mem_req;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic [15:0] id_inst;
    logic [15:0] id_pc;
    logic        id_valid;
    logic        fetch_err;

    int passed = 0;
    int total  = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .cur_pc     (cur_pc),
        .pre_pc     (pre_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .mem_data   (mem_data),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_valid   (id_valid),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        redir;
        logic [15:0] redirPc;
        logic        stl;
        logic        rdy;
        logic [15:0] data;
        logic [15:0] prePc;
        logic [15:0] eCur;
        logic [15:0] eInst;
        logic [15:0] ePc;
        logic        eValid;
        logic        eReq;
        logic        eErr;
    } vec_t;

    vec_t vecs[20];
    vec_t expQ[$];

    function automatic vec_t mk(logic redir, logic [15:0] redirPc, logic stl, logic rdy,
                                logic [15:0] data, logic [15:0] prePc,
                                logic [15:0] eCur, logic [15:0] eInst, logic [15:0] ePc,
                                logic eValid, logic eReq, logic eErr);
        vec_t v;
        v.redir = redir;   v.redirPc = redirPc; v.stl = stl;   v.rdy = rdy;
        v.data = data;     v.prePc = prePc;     v.eCur = eCur; v.eInst = eInst;
        v.ePc = ePc;       v.eValid = eValid;   v.eReq = eReq; v.eErr = eErr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        redirect    = v.redir;
        redirect_pc = v.redirPc;
        stall       = v.stl;
        mem_ready   = v.rdy;
        mem_data    = v.data;
        pre_pc      = v.prePc;
        expQ.push_back(v);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        chk({tag, ".cur_pc"},    cur_pc,           e.eCur);
        chk({tag, ".id_inst"},   id_inst,          e.eInst);
        chk({tag, ".id_pc"},     id_pc,            e.ePc);
        chk({tag, ".id_valid"},  16'(id_valid),    16'(e.eValid));
        chk({tag, ".mem_req"},   16'(mem_req),     16'(e.eReq));
        chk({tag, ".fetch_err"}, 16'(fetch_err),   16'(e.eErr));
    endtask

    task automatic chkReset(input string tag);
        chk({tag, ".cur_pc"},    cur_pc,         16'h0000);
        chk({tag, ".id_inst"},   id_inst,        16'h0800);
        chk({tag, ".id_pc"},     id_pc,          16'h0000);
        chk({tag, ".id_valid"},  16'(id_valid),  16'h0000);
        chk({tag, ".mem_req"},   16'(mem_req),   16'h0000);
        chk({tag, ".fetch_err"}, 16'(fetch_err), 16'h0000);
    endtask

    initial begin
        //             rd rpc      st rdy data     pre      eCur     eInst    ePc      v  rq er
        vecs[0]  = mk(0, 16'h0000, 0, 1, 16'h1000, 16'h0004, 16'h0004, 16'h1000, 16'h0000, 1, 1, 0);
        vecs[1]  = mk(0, 16'h0000, 0, 1, 16'h1001, 16'h0008, 16'h0008, 16'h1001, 16'h0004, 1, 1, 0);
        vecs[2]  = mk(0, 16'h0000, 1, 1, 16'h1002, 16'h000C, 16'h0008, 16'h1001, 16'h0004, 1, 0, 0);
        vecs[3]  = mk(0, 16'h0000, 1, 1, 16'hDEAD, 16'h0050, 16'h0008, 16'h1001, 16'h0004, 1, 0, 0);
        vecs[4]  = mk(0, 16'h0000, 1, 1, 16'hDEAD, 16'h0050, 16'h0008, 16'h1001, 16'h0004, 1, 0, 0);
        vecs[5]  = mk(0, 16'h0000, 0, 1, 16'hBEEF, 16'h0050, 16'h000C, 16'h1002, 16'h0008, 1, 1, 0);
        vecs[6]  = mk(0, 16'h0000, 0, 1, 16'h1003, 16'h0010, 16'h0010, 16'h1003, 16'h000C, 1, 1, 0);
        vecs[7]  = mk(1, 16'h0040, 1, 1, 16'hBAD0, 16'h0014, 16'h0040, 16'h0800, 16'h0000, 0, 1, 0);
        vecs[8]  = mk(0, 16'h0000, 0, 1, 16'h2000, 16'h0044, 16'h0044, 16'h2000, 16'h0040, 1, 1, 0);
        vecs[9]  = mk(0, 16'h0000, 1, 1, 16'h2001, 16'h0048, 16'h0044, 16'h2000, 16'h0040, 1, 0, 0);
        vecs[10] = mk(1, 16'h0080, 1, 0, 16'h2002, 16'h0048, 16'h0080, 16'h0800, 16'h0000, 0, 1, 0);
        vecs[11] = mk(0, 16'h0000, 0, 1, 16'h3000, 16'h0084, 16'h0084, 16'h3000, 16'h0080, 1, 1, 0);
        vecs[12] = mk(0, 16'h0000, 0, 0, 16'h3333, 16'h0088, 16'h0084, 16'h0800, 16'h0080, 0, 1, 0);
        vecs[13] = mk(0, 16'h0000, 1, 0, 16'h3333, 16'h0088, 16'h0084, 16'h0800, 16'h0080, 0, 1, 0);
        vecs[14] = mk(0, 16'h0000, 0, 1, 16'h3001, 16'h0088, 16'h0088, 16'h3001, 16'h0084, 1, 1, 0);
        vecs[15] = mk(0, 16'h0000, 0, 1, 16'h3002, 16'hFFFC, 16'hFFFC, 16'h3002, 16'h0088, 1, 1, 0);
        vecs[16] = mk(0, 16'h0000, 0, 1, 16'h3003, 16'h0000, 16'h0000, 16'h3003, 16'hFFFC, 1, 1, 0);
        vecs[17] = mk(0, 16'h0000, 0, 1, 16'h3004, 16'h0004, 16'h0004, 16'h3004, 16'h0000, 1, 1, 0);
        vecs[18] = mk(1, 16'hFFFF, 0, 0, 16'h3005, 16'h0008, 16'hFFFF, 16'h0800, 16'h0000, 0, 1, 0);
        vecs[19] = mk(0, 16'h0000, 0, 1, 16'h3005, 16'h0002, 16'h0002, 16'h3005, 16'hFFFF, 1, 1, 0);

        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        mem_ready = 1'b0; mem_data = '0; pre_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chkReset("reset");

        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // 14 wait cycles stay below the timeout.
        for (int i = 0; i < 14; i++) begin
            step(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h0006, 16'h0002, 16'h0800, 16'hFFFF, 0, 1, 0),
                 $sformatf("wait14_%0d", i));
        end
        step(mk(0, 16'h0000, 0, 1, 16'h4000, 16'h0006, 16'h0006, 16'h4000, 16'h0002, 1, 1, 0), "wait14_done");

        // 15 wait cycles raise the sticky error on the 15th edge.
        for (int i = 0; i < 17; i++) begin
            step(mk(0, 16'h0000, 0, 0, 16'h0000, 16'h000A, 16'h0006, 16'h0800, 16'h0002, 0, 1,
                    (i >= 14) ? 1'b1 : 1'b0),
                 $sformatf("wait15_%0d", i));
        end
        step(mk(0, 16'h0000, 0, 1, 16'h4001, 16'h000A, 16'h000A, 16'h4001, 16'h0006, 1, 1, 1), "err_sticky");

        // Enter HOLD, then assert reset between edges.
        step(mk(0, 16'h0000, 1, 1, 16'h4002, 16'h000E, 16'h000A, 16'h4001, 16'h0006, 1, 0, 1), "hold_pre_rst");
        #2;
        rst = 1'b0;
        #1;
        chkReset("async_rst");
        #2;
        rst = 1'b1;
        step(mk(0, 16'h0000, 0, 1, 16'h5000, 16'h0004, 16'h0004, 16'h5000, 16'h0000, 1, 1, 0), "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
